mx_quantize_fp: RTL
===================

# mx_quantize_fp

Streaming MX re-quantizer that converts a row of wide signed fixed-point matmul results, sharing one power-of-two scale, back into MX floating-point format: `bit_width`-bit E`exp_width`M`man_width` elements plus one shared `scale_width`-bit exponent per block of `k` elements. It sits downstream of the FP matmul/dot-product array. It produces the element and scale vectors that the next matmul stage consumes as its `A`/`B` and `S_A`/`S_B` operands. Blocks are processed serially, one per cycle, behind a valid/ready handshake on both sides.

## Interface
- `vec_elem_count`, 8: elements per row.
- `k`, 2: MX block size; `block_count = vec_elem_count/k`.
- `in_width`, 32: signed input element width.
- `bit_width`, 8: output element width, equal to 1 + `exp_width` + `man_width`.
- `exp_width`, 5: output element exponent width; element bias `eb = 2^(exp_width-1)-1`; `emax = eb`.
- `man_width`, 2: output element mantissa width.
- `scale_width`, 8: scale width; bias 127. Value 255 is reserved and never emitted.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  input row valid.
- `o_ready`  out  1  block can accept a row.
- `i_data`  in  `[in_width]` x `vec_elem_count`  signed results.
- `i_scale`  in  `scale_width`  shared input exponent (biased).
- `o_valid`  out  1  output row valid.
- `i_ready`  in  1  downstream accepts the row.
- `o_data`  out  `[bit_width]` x `vec_elem_count`  MX elements.
- `o_scale`  out  `[scale_width]` x `block_count`  per-block shared scales.

## Operation
- FSM has three states:
  - IDLE: `o_ready`=1. When `i_valid`, capture `i_data`/`i_scale`, set b=0, and go to SCAN.
  - SCAN: encode block b in one cycle, write its results into the output registers, then b++. After block `block_count-1`, go to EMIT.
  - EMIT: `o_valid`=1, with `o_data`/`o_scale` held stable. When `i_ready`, go to IDLE.
- Per-block encoding:
  - m = max |x| over the block. |−2^(in_width-1)| is treated as 2^(in_width-1).
  - m=0: scale 0, all elements 0x00.
  - Otherwise p = floor(log2 m) and S = `i_scale` + p − emax, computed signed.
  - If S<1, flush the block: scale 0, elements 0.
  - If S>254, set scale 254 and saturate every nonzero element to ±max-normal.
  - Otherwise scale = S.
- Per-element encoding, for nonzero x with e = floor(log2|x|):
  - Exponent field E = e − p + emax + eb.
  - E ≥ 1: normal; mantissa is the `man_width` bits below the leading one.
  - E ≤ 0: subnormal; shift the significand right by 1−E and set exponent field 0.
  - Rounding follows the Configuration section. A mantissa carry increments E. If E then exceeds the maximum normal exponent, saturate to max-normal (no Inf/NaN).
  - Sign-magnitude output: sign bit = sign of x, and −0 is emitted as 0x00.
- All `o_data` and `o_scale` lanes are registered and are written only in SCAN.

## Timing
- Reset: state IDLE, `o_valid`=0, `o_ready`=1 on the cycle after reset, all `o_data`/`o_scale`=0, b=0.
- Reset asserted in SCAN or EMIT aborts the row; no partial row is emitted.
- If a row is accepted on edge t, `o_valid` rises after edge t+`block_count`, which is a latency of `block_count`+1 cycles.
- Throughput is one row per `block_count`+2 cycles when `i_ready` is held high.
- `o_ready` is 0 outside IDLE. `i_valid` is ignored while `o_ready`=0.
- There is no combinational path from `i_valid` to `o_ready`, or from `i_ready` to `o_valid`.
- Back-pressure: EMIT holds indefinitely, with outputs unchanged, until `i_ready`.

## Configuration
- `MX_QUANT_RNE_EN`:
  - Defined: round-to-nearest-even using guard plus sticky bits.
  - Undefined: truncate toward zero (magnitude) and drop the rounding logic.
- Flush and saturation rules are identical in both modes.

## Test plan
All tests use defaults: E5M2, bias 15, emax 15.
- Block [96, −3], `i_scale`=127 -> `o_scale`=118, elements 0x7A, 0xE6. `o_valid` is asserted 5 cycles after acceptance.
- Block [11, 0], `i_scale`=127 -> scale 115. Element 0x7A with `MX_QUANT_RNE_EN` defined (tie rounds to even, up), 0x79 without; second element 0x00.
- All-zero row -> all scales 0 and all elements 0x00. Block [1, 1] with `i_scale`=10 -> S<1, block flushed to 0.
- Block [2^30, 1] with `i_scale`=250 -> scale 254, elements 0x7B, 0x7B (saturated).
- `i_ready` held low for 10 cycles in EMIT -> outputs stable, `o_ready`=0, and a second `i_valid` is ignored. Raising `i_ready` then accepts the next row.
- `i_rst` pulsed at SCAN block 2 -> IDLE on the next cycle, `o_valid` never rises, outputs 0. The next row processes normally.

Source files
------------

// File: rtl/mx_quantize_fp.sv
// rtl/mx_quantize_fp.sv - streaming MX re-quantizer: fixed-point row -> E/M elements plus per-block scales
// Define MX_QUANT_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module mx_quantize_fp #(
  parameter int VEC_ELEM_COUNT = 8,
  parameter int K              = 2,
  parameter int IN_WIDTH       = 32,
  parameter int EXP_WIDTH      = 5,
  parameter int MAN_WIDTH      = 2,
  parameter int BIT_WIDTH      = 1 + EXP_WIDTH + MAN_WIDTH,
  parameter int SCALE_WIDTH    = 8
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_valid,
  output logic                                         o_ready,
  input  logic [VEC_ELEM_COUNT-1:0][IN_WIDTH-1:0]      i_data,
  input  logic [SCALE_WIDTH-1:0]                       i_scale,
  output logic                                         o_valid,
  input  logic                                         i_ready,
  output logic [VEC_ELEM_COUNT-1:0][BIT_WIDTH-1:0]     o_data,
  output logic [VEC_ELEM_COUNT/K-1:0][SCALE_WIDTH-1:0] o_scale
);
  localparam int NB        = VEC_ELEM_COUNT / K;
  localparam int BW        = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW        = $clog2(IN_WIDTH);
  localparam int EB        = 2**(EXP_WIDTH-1) - 1;
  localparam int EMAX      = EB;
  localparam int SW        = 16;
  localparam int FW        = EXP_WIDTH + MAN_WIDTH;
  localparam int SCALE_MAX = 2**SCALE_WIDTH - 2;
  localparam logic [FW-1:0] MAX_NORM = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {MAN_WIDTH{1'b1}}};
`ifdef MX_QUANT_RNE_EN
  localparam int XW = 2*IN_WIDTH - 1;
`else
  localparam int XW = MAN_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                                   state_q;
  logic [BW-1:0]                            b_q;
  logic [VEC_ELEM_COUNT-1:0][IN_WIDTH-1:0]  data_q;
  logic [SCALE_WIDTH-1:0]                   scale_q;
  logic                                     o_valid_q, o_ready_q;
  logic [VEC_ELEM_COUNT-1:0][BIT_WIDTH-1:0] o_data_q;
  logic [NB-1:0][SCALE_WIDTH-1:0]           o_scale_q;

  function automatic logic [IN_WIDTH-1:0] mag_of(input logic [IN_WIDTH-1:0] x);
    return x[IN_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [LW-1:0] msb_pos(input logic [IN_WIDTH-1:0] a);
    logic [LW-1:0] pos;
    pos = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      if (a[i]) pos = LW'(i);
    return pos;
  endfunction

  // Leading one is aligned to the top of a double-width word so the subnormal
  // right shift keeps every dropped bit available for guard/sticky.
  function automatic logic [BIT_WIDTH-1:0] enc_elem(input logic [IN_WIDTH-1:0] x,
                                                    input logic [LW-1:0] p,
                                                    input logic sat);
    logic [IN_WIDTH-1:0]   a;
    logic [LW-1:0]         e;
    logic signed [SW-1:0]  ex;
    logic [SW-1:0]         sh;
    logic [XW-1:0]         ext;
    logic [FW-1:0]         f;
    a   = mag_of(x);
    e   = msb_pos(a);
    ex  = $signed(SW'(e)) - $signed(SW'(p)) + SW'(EMAX + EB);
    sh  = (ex < 1) ? SW'(1 - ex) : '0;
    ext = XW'(({a << (LW'(IN_WIDTH-1) - e), IN_WIDTH'(0)} >> sh) >> (2*IN_WIDTH-1-XW));
    f   = {(ex < 1) ? EXP_WIDTH'(0) : ex[EXP_WIDTH-1:0], ext[XW-1 -: MAN_WIDTH]};
`ifdef MX_QUANT_RNE_EN
    if (ext[XW-1-MAN_WIDTH] && ((|ext[XW-2-MAN_WIDTH:0]) || f[0]))
      f = f + 1'b1;
`endif
    if (sat || (f[FW-1 -: EXP_WIDTH] == '1))
      f = MAX_NORM;
    if ((a == '0) || (f == '0))
      return '0;
    return {x[IN_WIDTH-1], f};
  endfunction

  logic [IN_WIDTH-1:0]        blk_max;
  logic [LW-1:0]              blk_p;
  logic signed [SW-1:0]       blk_s;
  logic                       blk_flush, blk_sat;
  logic [SCALE_WIDTH-1:0]     blk_scale_d;
  logic [K-1:0][BIT_WIDTH-1:0] blk_elem_d;

  always_comb begin
    blk_max = '0;
    for (int j = 0; j < K; j++)
      if (mag_of(data_q[int'(b_q)*K + j]) > blk_max)
        blk_max = mag_of(data_q[int'(b_q)*K + j]);
    blk_p       = msb_pos(blk_max);
    blk_s       = $signed(SW'(scale_q)) + $signed(SW'(blk_p)) - SW'(EMAX);
    blk_flush   = (blk_max == '0) || (blk_s < 1);
    blk_sat     = !blk_flush && (blk_s > SCALE_MAX);
    blk_scale_d = blk_flush ? '0 : (blk_sat ? SCALE_WIDTH'(SCALE_MAX) : blk_s[SCALE_WIDTH-1:0]);
    for (int j = 0; j < K; j++)
      blk_elem_d[j] = blk_flush ? '0 : enc_elem(data_q[int'(b_q)*K + j], blk_p, blk_sat);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      b_q       <= '0;
      data_q    <= '0;
      scale_q   <= '0;
      o_valid_q <= 1'b0;
      o_ready_q <= 1'b1;
      o_data_q  <= '0;
      o_scale_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          data_q    <= i_data;
          scale_q   <= i_scale;
          b_q       <= '0;
          o_ready_q <= 1'b0;
          state_q   <= SCAN;
        end
        SCAN: begin
          o_scale_q[b_q] <= blk_scale_d;
          for (int j = 0; j < K; j++)
            o_data_q[int'(b_q)*K + j] <= blk_elem_d[j];
          b_q <= b_q + 1'b1;
          if (b_q == BW'(NB-1)) begin
            o_valid_q <= 1'b1;
            state_q   <= EMIT;
          end
        end
        EMIT: if (i_ready) begin
          o_valid_q <= 1'b0;
          o_ready_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid = o_valid_q;
  assign o_ready = o_ready_q;
  assign o_data  = o_data_q;
  assign o_scale = o_scale_q;
endmodule
